// File: rtl/adder_driver_if.sv
// Operand/result bus between adder_driver (master) and the adder under test (slave).
interface adder_driver_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] sig_a;
    logic [WIDTH-1:0] sig_b;
    logic [WIDTH-1:0] sig_sum;

    modport master (output sig_a, output sig_b, input sig_sum);
    modport slave  (input sig_a, input sig_b, output sig_sum);
endinterface

// File: rtl/adder_driver.sv
// Stimulus-and-check engine for a WIDTH-bit adder with LATENCY-edge result latency.
// Define ADDER_DRIVER_LFSR_EN for LFSR operands (WIDTH=8 only) instead of the index sweep.
module adder_driver #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vectors,
    adder_driver_if.master     bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [WIDTH-1:0]   first_err_a,
    output logic [WIDTH-1:0]   first_err_b,
    output logic [WIDTH-1:0]   first_err_sum
);
    localparam int unsigned      VW         = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       DRAIN_LAST = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           r_state, w_next;
    logic             w_accept, w_issue;
    logic [CNT_W-1:0] r_num, r_cnt, r_err;
    logic [VW-1:0]    r_vec, w_vec_step, w_seed;
    logic [2:0]       r_drain;
    logic [WIDTH-1:0] r_a, r_b, r_fa, r_fb, r_fs;
    logic             r_busy, r_done, r_pass;
    logic [VW-1:0]    r_pipe_vec [LATENCY];
    logic             r_pipe_vld [LATENCY];
    logic [WIDTH-1:0] w_exp_a, w_exp_b, w_expect;
    logic             w_mismatch;

`ifdef ADDER_DRIVER_LFSR_EN
    always_comb begin
        w_seed     = VW'(16'hACE1);
        w_vec_step = r_vec[0] ? ((r_vec >> 1) ^ VW'(16'hB400)) : (r_vec >> 1);
    end
`else
    always_comb begin
        w_seed     = '0;
        w_vec_step = r_vec + VW'(1);
    end
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_issue  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_issue = 1'b1;
                if (r_cnt + CNT_ONE == r_num) w_next = DRAIN;
            end
            DRAIN: begin
                if (r_drain == DRAIN_LAST) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The expect pipeline carries the issued operands; the expected sum is formed at its tail.
    always_comb begin
        w_exp_a    = r_pipe_vec[LATENCY-1][WIDTH-1:0];
        w_exp_b    = r_pipe_vec[LATENCY-1][VW-1:WIDTH];
        w_expect   = w_exp_a + w_exp_b;
        w_mismatch = r_pipe_vld[LATENCY-1] && (bus.sig_sum != w_expect);
    end

    always_ff @(posedge clock) begin
        r_pipe_vec[0] <= r_vec;
        for (int unsigned k = 1; k < LATENCY; k++) r_pipe_vec[k] <= r_pipe_vec[k-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_drain <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fa    <= '0;
            r_fb    <= '0;
            r_fs    <= '0;
            for (int unsigned k = 0; k < LATENCY; k++) r_pipe_vld[k] <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (r_state == RUN) || (r_state == DRAIN);
            r_done  <= (r_state == DONE);
            r_drain <= (r_state == DRAIN) ? r_drain + 3'd1 : 3'd0;

            r_pipe_vld[0] <= w_issue;
            for (int unsigned k = 1; k < LATENCY; k++) r_pipe_vld[k] <= r_pipe_vld[k-1];

            if (w_issue) begin
                {r_b, r_a} <= r_vec;
                r_vec      <= w_vec_step;
                r_cnt      <= r_cnt + CNT_ONE;
            end

            // The pipeline is empty whenever a start is accepted, so the clear cannot race a compare.
            if (w_accept) begin
                r_num  <= num_vectors;
                r_cnt  <= '0;
                r_vec  <= w_seed;
                r_err  <= '0;
                r_pass <= 1'b0;
                r_fa   <= '0;
                r_fb   <= '0;
                r_fs   <= '0;
            end else if (w_mismatch) begin
                r_err <= r_err + CNT_ONE;
                if (r_err == '0) begin
                    r_fa <= w_exp_a;
                    r_fb <= w_exp_b;
                    r_fs <= bus.sig_sum;
                end
            end

            if (r_state == DONE) r_pass <= (r_err == '0);
        end
    end

    always_comb begin
        bus.sig_a     = r_a;
        bus.sig_b     = r_b;
        busy          = r_busy;
        done          = r_done;
        pass          = r_pass;
        err_count     = r_err;
        first_err_a   = r_fa;
        first_err_b   = r_fb;
        first_err_sum = r_fs;
    end
endmodule

// File: tb/tb_adder_driver.sv
// Directed bench for adder_driver: one LATENCY=1 driver with selectable adder models,
// one LATENCY=3 driver facing a 3-edge adder model.
module tb_adder_driver;
    logic        clock = 1'b0;
    logic        reset;
    logic        start1, start3;
    logic [15:0] num1, num3;
    logic        busy1, done1, pass1, busy3, done3, pass3;
    logic [15:0] err1, err3;
    logic [7:0]  fa1, fb1, fs1, fa3, fb3, fs3;
    logic [7:0]  m1_q1, m1_q2, m3_q1, m3_q2;
    int          mode;
    int          n_pass = 0;
    int          n_total = 0;
    int          de;
    logic [7:0]  ca, cb;

    adder_driver_if #(.WIDTH(8)) bus1 ();
    adder_driver_if #(.WIDTH(8)) bus3 ();

    adder_driver #(.WIDTH(8), .LATENCY(1), .CNT_W(16)) u_l1 (
        .clock(clock), .reset(reset), .start(start1), .num_vectors(num1), .bus(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_a(fa1), .first_err_b(fb1), .first_err_sum(fs1)
    );

    adder_driver #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) u_l3 (
        .clock(clock), .reset(reset), .start(start3), .num_vectors(num3), .bus(bus3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_a(fa3), .first_err_b(fb3), .first_err_sum(fs3)
    );

    always #5 clock = ~clock;

    // A LATENCY-L adder is L-1 registers after the add; L=1 is purely combinational.
    always_ff @(posedge clock) begin
        m1_q1 <= bus1.sig_a + bus1.sig_b;
        m1_q2 <= m1_q1;
        m3_q1 <= bus3.sig_a + bus3.sig_b;
        m3_q2 <= m3_q1;
    end

    // mode 0: ideal, 1: sum bit 0 stuck at 0, 2: 3-edge model
    assign bus1.sig_sum = (mode == 1) ? ((bus1.sig_a + bus1.sig_b) & 8'hFE) :
                          (mode == 2) ? m1_q2 : (bus1.sig_a + bus1.sig_b);
    assign bus3.sig_sum = m3_q2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Pulses start (sampled at E0), then waits for done; returns the edge index at which done
    // was seen (-1 on timeout) and the operands visible after edge cap_edge.
    task automatic run(input int which, input logic [15:0] n, input int cap_edge,
                       output int done_edge, output logic [7:0] a, output logic [7:0] b);
        done_edge = -1;
        a = 'x;
        b = 'x;
        @(negedge clock);
        if (which == 3) begin start3 = 1'b1; num3 = n; end
        else begin start1 = 1'b1; num1 = n; end
        @(posedge clock); #1;
        start1 = 1'b0;
        start3 = 1'b0;
        for (int e = 1; e <= int'(n) + 20; e++) begin
            @(posedge clock); #1;
            if (e == cap_edge) begin
                a = (which == 3) ? bus3.sig_a : bus1.sig_a;
                b = (which == 3) ? bus3.sig_b : bus1.sig_b;
            end
            if ((which == 3) ? done3 : done1) begin
                done_edge = e;
                break;
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        num1   = '0;
        num3   = '0;
        mode   = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_sig_a", bus1.sig_a, 8'h00);
        check("rst_sig_b", bus1.sig_b, 8'h00);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_pass", pass1, 1'b0);
        check("rst_err", err1, 16'h0);
        check("rst_fea", fa1, 8'h00);
        check("rst_feb", fb1, 8'h00);
        check("rst_fes", fs1, 8'h00);
        reset = 1'b0;

        // N=256 ideal adder
        run(1, 16'd256, 256, de, ca, cb);
        check("n256_done_edge", de, 258);
        check("n256_err", err1, 16'h0);
        check("n256_pass", pass1, 1'b1);
        check("n256_v255_a", ca, 8'hFF);
        check("n256_v255_b", cb, 8'h00);
        check("n256_busy_at_done", busy1, 1'b0);
        @(posedge clock); #1;
        check("n256_done_one_cycle", done1, 1'b0);

        // Carry discard: vector 0x1FF is a=FF b=01, sum wraps to 0
        run(1, 16'h0200, 16'h0200, de, ca, cb);
        check("n512_done_edge", de, 16'h0200 + 2);
        check("n512_v1ff_a", ca, 8'hFF);
        check("n512_v1ff_b", cb, 8'h01);
        check("n512_err", err1, 16'h0);
        check("n512_pass", pass1, 1'b1);

        // Stuck-at-0 on sum bit 0: vectors 1 and 3 fail
        mode = 1;
        run(1, 16'd4, 0, de, ca, cb);
        check("stuck_done_edge", de, 6);
        check("stuck_err", err1, 16'd2);
        check("stuck_fea", fa1, 8'h01);
        check("stuck_feb", fb1, 8'h00);
        check("stuck_fes", fs1, 8'h00);
        check("stuck_pass", pass1, 1'b0);

        // N=0 goes straight to done
        mode = 0;
        run(1, 16'd0, 0, de, ca, cb);
        check("n0_done_edge", de, 1);
        check("n0_pass", pass1, 1'b1);
        check("n0_err", err1, 16'h0);

        // N=10 with a second start while busy
        @(negedge clock);
        start1 = 1'b1;
        num1   = 16'd10;
        @(posedge clock); #1;
        start1 = 1'b0;
        check("n10_busy_after_E0", busy1, 1'b0);
        de = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock); #1;
            start1 = 1'b0;
            if (e == 1) check("n10_busy_at_E1", busy1, 1'b1);
            if (e == 3) begin start1 = 1'b1; num1 = 16'd3; end
            if (done1) begin de = e; break; end
        end
        start1 = 1'b0;
        check("n10_done_edge", de, 12);
        check("n10_err", err1, 16'h0);
        check("n10_pass", pass1, 1'b1);

        // LATENCY=3 driver against a 3-edge adder
        run(3, 16'd8, 0, de, ca, cb);
        check("l3_done_edge", de, 12);
        check("l3_err", err3, 16'h0);
        check("l3_pass", pass3, 1'b1);

        // Same 3-edge adder against the LATENCY=1 driver: vectors 2..7 see stale sums
        mode = 2;
        run(1, 16'd8, 0, de, ca, cb);
        check("l3model_l1drv_done_edge", de, 10);
        check("l3model_l1drv_err_ge6", (err1 >= 16'd6), 1'b1);
        check("l3model_l1drv_pass", pass1, 1'b0);

        // Reset sampled at E5 of an N=100 run with a faulty adder
        mode = 1;
        @(negedge clock);
        start1 = 1'b1;
        num1   = 16'd100;
        @(posedge clock); #1;
        start1 = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        check("rst_run_err_before", err1, 16'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_run_busy", busy1, 1'b0);
        check("rst_run_sig_a", bus1.sig_a, 8'h00);
        check("rst_run_sig_b", bus1.sig_b, 8'h00);
        check("rst_run_err", err1, 16'h0);
        @(posedge clock); #1;
        check("rst_run_no_compare", err1, 16'h0);

        mode = 0;
        run(1, 16'd16, 0, de, ca, cb);
        check("after_rst_done_edge", de, 18);
        check("after_rst_err", err1, 16'h0);
        check("after_rst_pass", pass1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
